// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Purpose  : Converts one load/store request at a time into a single-cycle
//            RAM access. Stores are lane-replicated with a byte mask. Loads
//            are lane-extracted and then zero- or sign-extended.
//            Sequence: IDLE -> ACCESS -> (CAPTURE, loads only) -> RESP.
// Ports    : clock/reset                   rising-edge clock, sync active-low reset
//            req_valid/req_ready           request handshake (ready only in IDLE)
//            req_wen/addr/wdata/size/unsigned  request fields
//            resp_valid/resp_ready         response handshake
//            resp_rdata/resp_err           extended load data / misalign flag
//            mem_valid/mem_wen             RAM strobe / write enable
//            mem_waddr/mem_raddr           word-aligned RAM address
//            mem_wdata/mem_wmask           lane-replicated data / byte mask
//            mem_rdata                     RAM read data (cycle after strobe)
// Options  : LSU_MISALIGN_TRAP_EN -- misaligned half/word accesses skip RAM
//            and respond with resp_err=1. If undefined, low address bits
//            are truncated.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Request fields captured on accept
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        wen_q;

  logic        w_accept;
  logic        w_req_misalign;
  logic        w_is_byte;
  logic        w_is_half;
  logic [3:0]  w_mask;
  logic [31:0] w_lane_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  assign w_accept = (state_q == S_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  // req_size[1] covers both word (2) and reserved (3), which is treated as word
  assign w_req_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_req_misalign = 1'b0;
`endif

  // Sizes 2 and 3 are both handled as word
  assign w_is_byte = (size_q == 2'd0);
  assign w_is_half = (size_q == 2'd1);

  // Lane mask and replicated store data. A half access ignores addr[0] and a
  // word access ignores addr[1:0], which truncates misaligned offsets.
  always_comb begin
    w_mask       = 4'b1111;
    w_lane_wdata = wdata_q;
    if (w_is_byte) begin
      w_mask       = 4'b0001 << addr_q[1:0];
      w_lane_wdata = {4{wdata_q[7:0]}};
    end else if (w_is_half) begin
      w_mask       = addr_q[1] ? 4'b1100 : 4'b0011;
      w_lane_wdata = {2{wdata_q[15:0]}};
    end
  end

  // Load lane selection and extension, using the same offsets as the mask
  always_comb begin
    w_ld_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    w_ld_byte = mem_rdata[7:0];
      2'd1:    w_ld_byte = mem_rdata[15:8];
      2'd2:    w_ld_byte = mem_rdata[23:16];
      default: w_ld_byte = mem_rdata[31:24];
    endcase
    w_ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (w_is_byte) begin
      w_ld_data = {{24{~uns_q & w_ld_byte[7]}}, w_ld_byte};
    end else if (w_is_half) begin
      w_ld_data = {{16{~uns_q & w_ld_half[15]}}, w_ld_half};
    end else begin
      w_ld_data = mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Clearing here makes stores and trapped accesses return 0
          rdata_d = 32'h0;
          err_d   = w_req_misalign;
          state_d = w_req_misalign ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = wen_q ? S_RESP : S_CAPTURE;
      end
      S_CAPTURE: begin
        rdata_d = w_ld_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The request datapath needs no reset. It is only observed after an accept.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wen_q   <= req_wen;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = (state_q == S_ACCESS);
  assign mem_wen    = (state_q == S_ACCESS) && wen_q;
  assign mem_wmask  = (state_q == S_ACCESS) ? w_mask : 4'b0000;
  assign mem_waddr  = {addr_q[31:2], 2'b00};
  assign mem_raddr  = {addr_q[31:2], 2'b00};
  assign mem_wdata  = w_lane_wdata;

endmodule
`default_nettype wire
